// File: rtl/mips_pkg.sv
// Shared pipeline constants: write-back select codes, register index width, reset PC.
// Used by the write-back stage and the controller that drives W_WDSel.
package mips_pkg;

   localparam int unsigned REG_IDX_W = 5;
   localparam logic [31:0] RESET_PC  = 32'h0000_3000;

   typedef logic [2:0] wdsel_t;

   localparam wdsel_t WDSEL_ALU = 3'd0;
   localparam wdsel_t WDSEL_DM  = 3'd1;
   localparam wdsel_t WDSEL_PC8 = 3'd2;
   localparam wdsel_t WDSEL_EXT = 3'd3;
   localparam wdsel_t WDSEL_CMP = 3'd4;
   localparam wdsel_t WDSEL_MD  = 3'd5;
   localparam wdsel_t WDSEL_CP0 = 3'd6;

endpackage

// File: rtl/wb_regfile_if.sv
// W-stage inputs, D-stage read ports and commit trace of the write-back stage.
// No handshake: the stage never stalls, bubbles arrive as W_A3 = 0.
interface wb_regfile_if;
   import mips_pkg::*;

   logic [31:0]          W_ALU_O;
   logic [31:0]          W_DM_O;
   logic [31:0]          W_PC;
   logic [31:0]          W_EXT_O;
   logic [31:0]          W_CMP_O;
   logic [31:0]          W_MUXMDSrc_O;
   logic [31:0]          W_CP0_O;
   logic [REG_IDX_W-1:0] W_A3;
   wdsel_t               W_WDSel;
   logic [REG_IDX_W-1:0] D_A1;
   logic [REG_IDX_W-1:0] D_A2;
   logic [31:0]          D_RD1;
   logic [31:0]          D_RD2;
   logic                 grf_we;
   logic [REG_IDX_W-1:0] grf_addr;
   logic [31:0]          grf_wdata;
   logic [31:0]          grf_pc;

   modport master (
      output W_ALU_O, W_DM_O, W_PC, W_EXT_O, W_CMP_O, W_MUXMDSrc_O, W_CP0_O,
      output W_A3, W_WDSel, D_A1, D_A2,
      input  D_RD1, D_RD2, grf_we, grf_addr, grf_wdata, grf_pc
   );

   modport slave (
      input  W_ALU_O, W_DM_O, W_PC, W_EXT_O, W_CMP_O, W_MUXMDSrc_O, W_CP0_O,
      input  W_A3, W_WDSel, D_A1, D_A2,
      output D_RD1, D_RD2, grf_we, grf_addr, grf_wdata, grf_pc
   );

endinterface

// File: rtl/wb_mux.sv
// Write-back datum select (7 sources plus zero for code 7), including the link PC + 8.
// Purely combinational, zero latency; no backpressure.
module wb_mux
   import mips_pkg::*;
(
   input  logic [31:0] alu_o,
   input  logic [31:0] dm_o,
   input  logic [31:0] pc,
   input  logic [31:0] ext_o,
   input  logic [31:0] cmp_o,
   input  logic [31:0] md_o,
   input  logic [31:0] cp0_o,
   input  wdsel_t      wdsel,
   output logic [31:0] wd
);

   logic [31:0] pc_plus8;

   // Link address wraps at 2^32; the carry out is deliberately dropped.
   assign pc_plus8 = pc + 32'd8;

   always_comb begin
      wd = 32'h0;
      case (wdsel)
         WDSEL_ALU: wd = alu_o;
         WDSEL_DM:  wd = dm_o;
         WDSEL_PC8: wd = pc_plus8;
         WDSEL_EXT: wd = ext_o;
         WDSEL_CMP: wd = cmp_o;
         WDSEL_MD:  wd = md_o;
         WDSEL_CP0: wd = cp0_o;
         default:   wd = 32'h0;
      endcase
   end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage + 32x32 register file with same-cycle write-through read bypass and commit trace.
// Writes land on the next posedge, visible on the read ports the same cycle; never stalls.
module wb_regfile #(
   parameter int          NREG     = 32,
   parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC
) (
   input  logic         clk,
   input  logic         reset,
   wb_regfile_if.slave  bus
);
   import mips_pkg::*;

   logic [31:0] regs_q [NREG];
   logic [31:0] regs_d [NREG];
   logic [31:0] wd;
   logic        we;

   wb_mux u_wb_mux (
      .alu_o (bus.W_ALU_O),
      .dm_o  (bus.W_DM_O),
      .pc    (bus.W_PC),
      .ext_o (bus.W_EXT_O),
      .cmp_o (bus.W_CMP_O),
      .md_o  (bus.W_MUXMDSrc_O),
      .cp0_o (bus.W_CP0_O),
      .wdsel (bus.W_WDSel),
      .wd    (wd)
   );

   assign we = (bus.W_A3 != '0) && !reset;

   always_comb begin
      regs_d = regs_q;
      if (we) begin
         regs_d[bus.W_A3] = wd;
      end
      regs_d[0] = 32'h0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= 32'h0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Bypass is gated by we, so it is inactive during reset and for bubbles.
   always_comb begin
      bus.D_RD1 = 32'h0;
      bus.D_RD2 = 32'h0;
      if (bus.D_A1 != '0) begin
         bus.D_RD1 = (we && bus.D_A1 == bus.W_A3) ? wd : regs_q[bus.D_A1];
      end
      if (bus.D_A2 != '0) begin
         bus.D_RD2 = (we && bus.D_A2 == bus.W_A3) ? wd : regs_q[bus.D_A2];
      end
   end

   assign bus.grf_we    = we;
   assign bus.grf_addr  = reset ? '0 : bus.W_A3;
   assign bus.grf_wdata = reset ? 32'h0 : wd;
   assign bus.grf_pc    = reset ? RESET_PC : bus.W_PC;

endmodule
